// File: rtl/bcd_mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//
// Shared types, constants and helpers for the BCD clock datapath counters.
//
// Contents
//   bcd_digit_t           one packed BCD digit (4 bits)
//   adj_state_t           manual-adjust auto-repeat FSM states
//   DEFAULT_REPEAT_DELAY  default hold time before auto-repeat starts
//   DEFAULT_REPEAT_RATE   default spacing of auto-repeat steps
//   MAX_BCD_DIGITS        widest value to_bcd() can produce
//   to_bcd()              integer -> packed BCD, for building compare constants
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } adj_state_t;

    localparam int DEFAULT_REPEAT_DELAY = 8;
    localparam int DEFAULT_REPEAT_RATE  = 4;
    localparam int MAX_BCD_DIGITS       = 8;

    // Elaboration-time conversion of a decimal parameter into packed BCD,
    // digit 0 in the low nibble. Callers truncate to their own width.
    function automatic logic [4*MAX_BCD_DIGITS-1:0] to_bcd(input int value);
        logic [4*MAX_BCD_DIGITS-1:0] r;
        int                          rem;
        r   = '0;
        rem = value;
        for (int i = 0; i < MAX_BCD_DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_adj_repeat.sv
// ---------------------------------------------------------------------------
// adj_repeat
//
// Manual-adjust step generator with hold-to-repeat. A valid direction
// (exactly one of adj_up / adj_dn) seen in IDLE produces one step at once,
// then after REPEAT_DELAY further held cycles a second step, then one step
// every REPEAT_RATE+1 cycles for as long as the same level stays held.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   adj_act   in   adjust currently effective (mode on, not blocked)
//   adj_up    in   debounced level, step +1
//   adj_dn    in   debounced level, step -1
//   clr       in   forces the FSM back to IDLE (used on parallel load)
//   step_up   out  one-cycle pulse, step the count up this cycle
//   step_dn   out  one-cycle pulse, step the count down this cycle
// ---------------------------------------------------------------------------
module adj_repeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic adj_act,
    input  logic adj_up,
    input  logic adj_dn,
    input  logic clr,
    output logic step_up,
    output logic step_dn
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE);

    adj_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_up_q, dir_up_d;

    logic          dir_valid;
    logic          req_up;
    logic          step;

    // Both levels high, or neither, is treated as "no direction".
    assign dir_valid = adj_up ^ adj_dn;
    assign req_up    = adj_up & ~adj_dn;

    // Next-state logic. The direction is latched only when leaving IDLE, so
    // swapping directions while held drops back to IDLE for one cycle before
    // the new direction is accepted. The counter is checked before it is
    // decremented, which gives the first repeat REPEAT_DELAY+1 cycles after
    // the initial step and REPEAT_RATE+1 cycles between later repeats.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        step     = 1'b0;

        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (adj_act && dir_valid) begin
                        step     = 1'b1;
                        dir_up_d = req_up;
                        cnt_d    = DELAY_LD;
                        state_d  = HOLD;
                    end
                end
                HOLD, RPT: begin
                    if (!adj_act || !dir_valid || (req_up != dir_up_q)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        step    = 1'b1;
                        cnt_d   = RATE_LD;
                        state_d = RPT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A step is only ever raised with a valid direction present, so the live
    // request selects which output pulses.
    assign step_up = step & req_up;
    assign step_dn = step & ~req_up;

    // State, repeat timer and latched direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dir_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
//
// Generic BCD modulo counter for one stage of the clock datapath
// (seconds/minutes 0..59, hours 0..23 or 1..12). Counts ticks from the lower
// stage, emits a carry on wrap, supports manual up/down adjust with
// hold-to-repeat, and a range-checked BCD parallel load.
// Per-cycle priority: load, then adjust step, then tick.
//
// Parameters
//   DIGITS        number of BCD digits (1..8), value width 4*DIGITS
//   MIN_VAL       lowest count, decimal
//   MAX_VAL       highest count, decimal
//   REPEAT_DELAY  held cycles after the first step before auto-repeat
//   REPEAT_RATE   cycles between auto-repeat steps
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous assert / synchronous release, active low
//   tick       in   one-cycle count enable from the lower stage
//   adj_mode   in   adjust mode, ticks ignored while effective
//   adj_block  in   alarm-set active, overrides adj_mode
//   adj_up     in   debounced level, step +1
//   adj_dn     in   debounced level, step -1
//   load       in   parallel-load strobe
//   load_bcd   in   BCD value to load, digit 0 = LSD
//   bcd        out  registered count, BCD
//   carry_out  out  one-cycle pulse when a tick wraps MAX_VAL -> MIN_VAL
//   load_err   out  one-cycle pulse when a load was rejected
// ---------------------------------------------------------------------------
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 23,
    parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                adj_mode,
    input  logic                adj_block,
    input  logic                adj_up,
    input  logic                adj_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_bcd,
    output logic [4*DIGITS-1:0] bcd,
    output logic                carry_out,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    localparam logic [W-1:0] MIN_BCD = W'(to_bcd(MIN_VAL));
    localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_VAL));

    logic [1:0]   rst_sync_q, rst_sync_d;
    logic         rst_n_int;

    logic [W-1:0] bcd_q, bcd_d;
    logic         carry_q, carry_d;
    logic         load_err_q, load_err_d;

    logic         adj_act;
    logic         step_up;
    logic         step_dn;
    logic         load_ok;
    logic         at_max;
    logic         at_min;

    // Digit-wise +1: each digit that rolls 9 -> 0 passes the increment up.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise -1: each digit that rolls 0 -> 9 passes the borrow up.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when every nibble is a legal decimal digit.
    function automatic logic bcd_digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // a <= b on valid BCD: the most significant differing digit decides.
    function automatic logic bcd_le(input logic [W-1:0] a, input logic [W-1:0] b);
        logic decided;
        logic res;
        decided = 1'b0;
        res     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                res     = (a[4*i +: 4] < b[4*i +: 4]);
            end
        end
        return res;
    endfunction

    // Reset synchroniser: assertion reaches every flop at once, release
    // is aligned to clk so no flop leaves reset on a different edge.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    assign adj_act = adj_mode & ~adj_block;

    // The load strobe also returns the repeat FSM to IDLE, so a held
    // adjust level restarts its delay after a load.
    adj_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_adj_repeat (
        .clk     (clk),
        .reset   (rst_n_int),
        .adj_act (adj_act),
        .adj_up  (adj_up),
        .adj_dn  (adj_dn),
        .clr     (load),
        .step_up (step_up),
        .step_dn (step_dn)
    );

    assign load_ok = bcd_digits_ok(load_bcd)
                   && bcd_le(MIN_BCD, load_bcd)
                   && bcd_le(load_bcd, MAX_BCD);

    assign at_max = (bcd_q == MAX_BCD);
    assign at_min = (bcd_q == MIN_BCD);

    // Count update with load > adjust step > tick. Steps are only raised
    // while adjust is effective, so a tick can never coincide with a step
    // and ticks arriving during adjust are simply dropped. Only the tick
    // wrap raises carry; adjust wraps stay local to this stage.
    always_comb begin
        bcd_d      = bcd_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (load_ok) begin
                bcd_d = load_bcd;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_up) begin
            bcd_d = at_max ? MIN_BCD : bcd_inc(bcd_q);
        end else if (step_dn) begin
            bcd_d = at_min ? MAX_BCD : bcd_dec(bcd_q);
        end else if (tick && !adj_act) begin
            if (at_max) begin
                bcd_d   = MIN_BCD;
                carry_d = 1'b1;
            end else begin
                bcd_d = bcd_inc(bcd_q);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            bcd_q      <= MIN_BCD;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd       = bcd_q;
    assign carry_out = carry_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_mod_counter
//
// Directed bench for bcd_mod_counter. Two instances share every input:
// dutHour24 (defaults, 0..23) and dutHour12 (1..12). Each scenario checks
// whichever instance it targets against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       adjMode;
    logic       adjBlock;
    logic       adjUp;
    logic       adjDn;
    logic       loadStb;
    logic [7:0] loadVal;

    logic [7:0] bcd24, bcd12;
    logic       carry24, carry12;
    logic       err24, err12;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expVal;

    // 10 time-unit clock.
    always #5 clk = ~clk;

    bcd_mod_counter dutHour24 (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .adj_mode  (adjMode),
        .adj_block (adjBlock),
        .adj_up    (adjUp),
        .adj_dn    (adjDn),
        .load      (loadStb),
        .load_bcd  (loadVal),
        .bcd       (bcd24),
        .carry_out (carry24),
        .load_err  (err24)
    );

    bcd_mod_counter #(
        .DIGITS       (2),
        .MIN_VAL      (1),
        .MAX_VAL      (12),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dutHour12 (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .adj_mode  (adjMode),
        .adj_block (adjBlock),
        .adj_up    (adjUp),
        .adj_dn    (adjDn),
        .load      (loadStb),
        .load_bcd  (loadVal),
        .bcd       (bcd12),
        .carry_out (carry12),
        .load_err  (err12)
    );

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, lets one rising edge consume them and
    // returns 1 time unit later so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic tickIn, input logic modeIn,
                                 input logic blockIn, input logic upIn,
                                 input logic dnIn, input logic loadIn,
                                 input logic [7:0] valIn);
        tick     = tickIn;
        adjMode  = modeIn;
        adjBlock = blockIn;
        adjUp    = upIn;
        adjDn    = dnIn;
        loadStb  = loadIn;
        loadVal  = valIn;
        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    // Watchdog so a stuck run still ends with a summary.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        tick     = 1'b0;
        adjMode  = 1'b0;
        adjBlock = 1'b0;
        adjUp    = 1'b0;
        adjDn    = 1'b0;
        loadStb  = 1'b0;
        loadVal  = 8'h00;
        reset    = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_bcd24", bcd24, 8'h00);
        checkOutput("rst_bcd12", bcd12, 8'h01);
        checkOutput("rst_carry24", 8'(carry24), 8'h00);
        checkOutput("rst_err24", 8'(err24), 8'h00);
        reset = 1'b1;
        applyIdle(3);
        checkOutput("post_rst_bcd24", bcd24, 8'h00);

        // Scenario 1: tick counting and wrap on 0..23
        for (int i = 1; i <= 23; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            if (i == 9)  checkOutput("tick_09", bcd24, 8'h09);
            if (i == 10) checkOutput("tick_10", bcd24, 8'h10);
            if (i == 20) checkOutput("tick_20", bcd24, 8'h20);
        end
        checkOutput("tick_23", bcd24, 8'h23);
        checkOutput("tick_23_carry", 8'(carry24), 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap_bcd", bcd24, 8'h00);
        checkOutput("wrap_carry", 8'(carry24), 8'h01);
        applyIdle(1);
        checkOutput("carry_one_cycle", 8'(carry24), 8'h00);
        checkOutput("wrap_hold", bcd24, 8'h00);

        // Scenario 2: 1..12 counter
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
        checkOutput("h12_load09", bcd12, 8'h09);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("h12_ripple", bcd12, 8'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
        checkOutput("h12_load12", bcd12, 8'h12);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("h12_wrap", bcd12, 8'h01);
        checkOutput("h12_wrap_carry", 8'(carry12), 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("h12_dn_wrap", bcd12, 8'h12);
        checkOutput("h12_dn_nocarry", 8'(carry12), 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("h12_dn_release", bcd12, 8'h12);
        applyIdle(1);

        // Scenario 3: hold-to-repeat with ticks ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        checkOutput("hold_load05", bcd24, 8'h05);
        expVal = 8'h05;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            if (k == 0 || k == 9 || k == 14 || k == 19) expVal = expVal + 8'd1;
            checkOutput($sformatf("hold_%0d", k), bcd24, expVal);
        end
        checkOutput("hold_nocarry", 8'(carry24), 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("hold_release", bcd24, 8'h09);

        // adj_block mid-hold stops steps, tick counting resumes
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("block_first_step", bcd24, 8'h10);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        checkOutput("block_pre", bcd24, 8'h10);
        for (int k = 5; k <= 15; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("blocked_%0d", k), bcd24, 8'h10);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("blocked_tick", bcd24, 8'h11);

        // adj_mode falling mid-hold: tick honoured, FSM back in IDLE
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("mode_first_step", bcd24, 8'h12);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        checkOutput("mode_hold", bcd24, 8'h12);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("mode_fall_tick", bcd24, 8'h13);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("mode_idle_step", bcd24, 8'h14);
        applyIdle(1);

        // Scenario 4: load validation and priority
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h17);
        checkOutput("load17", bcd24, 8'h17);
        checkOutput("load17_err", 8'(err24), 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h24);
        checkOutput("load24_bcd", bcd24, 8'h17);
        checkOutput("load24_err", 8'(err24), 8'h01);
        applyIdle(1);
        checkOutput("err_one_cycle", 8'(err24), 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1A);
        checkOutput("load1A_bcd", bcd24, 8'h17);
        checkOutput("load1A_err", 8'(err24), 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h23);
        checkOutput("load23", bcd24, 8'h23);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        checkOutput("load_tick_bcd", bcd24, 8'h05);
        checkOutput("load_tick_carry", 8'(carry24), 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("load00_h24", bcd24, 8'h00);
        checkOutput("load00_h12_err", 8'(err12), 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h13);
        checkOutput("load13_h24", bcd24, 8'h13);
        checkOutput("load13_h12_err", 8'(err12), 8'h01);
        checkOutput("load13_h12_bcd", bcd12, 8'h05);

        // Scenario 5: both directions held, then reset mid-repeat
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("both_dirs", bcd24, 8'h13);
        applyIdle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        checkOutput("rpt_before_reset", bcd24, 8'h02);
        reset = 1'b0;
        #2;
        checkOutput("async_reset_h24", bcd24, 8'h00);
        checkOutput("async_reset_h12", bcd12, 8'h01);
        adjUp   = 1'b0;
        adjMode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        applyIdle(3);
        checkOutput("post_reset_nostep", bcd24, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("repress_step", bcd24, 8'h01);
        applyIdle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
